// File: rtl/if_prefetch_unit.sv
// Decoupled instruction fetch: issues imem requests under a queue credit and buffers responses with their PCs.
// Latency: RVALID in cycle N shows as IF_VALID in N+1; ID backpressure stops issue once queue plus in-flight reach DEPTH.

module if_prefetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // The issue credit should make these impossible; they flag a broken credit loop.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clr) begin
      assert (!(i_push && o_full && !i_pop));
      assert (!(i_pop && o_empty));
    end
  end
endmodule

module if_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REDIRECT_VALID,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  input  logic            ID_READY,
  output logic            IF_VALID,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_PC_PLUS4,
  output logic [XLEN-1:0] IF_INSTRUCTION
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  logic            w_req;
  logic            w_credit;
  logic            w_issue;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_if_valid;
  logic [CW-1:0]   w_out_nxt;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_q_empty;
  logic            w_q_full;
  logic [CW-1:0]   w_q_count;
  logic [2*XLEN-1:0] w_head;

  assign w_redir_pc = REDIRECT_PC & ~XLEN'(3);
  assign w_credit   = ({1'b0, w_q_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_BOOT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   w_req = !REDIRECT_VALID && w_credit;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  assign IMEM_REQ  = w_req;
  assign IMEM_ADDR = r_fetch_pc;
  assign w_issue   = w_req & IMEM_GNT;

  // Anything returning during a redirect, or while old-stream debt remains, is stale.
  assign w_drop     = IMEM_RVALID & (REDIRECT_VALID | (r_discard != '0));
  assign w_push     = IMEM_RVALID & ~w_drop;
  assign w_if_valid = ~w_q_empty & ~REDIRECT_VALID;
  assign w_pop      = w_if_valid & ID_READY;

  always_comb begin
    w_out_nxt = r_outstanding;
    case ({w_issue, IMEM_RVALID})
      2'b10:   w_out_nxt = r_outstanding + CW'(1);
      2'b01:   w_out_nxt = r_outstanding - CW'(1);
      default: w_out_nxt = r_outstanding;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (REDIRECT_VALID) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_discard  <= w_out_nxt;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push)  r_resp_pc  <= r_resp_pc + XLEN'(4);
        if (IMEM_RVALID && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) assert (r_discard <= r_outstanding);
  end

  if_prefetch_fifo #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_clr      (REDIRECT_VALID),
    .i_push     (w_push),
    .i_push_dat ({r_resp_pc, IMEM_RDATA}),
    .i_pop      (w_pop),
    .o_empty    (w_q_empty),
    .o_full     (w_q_full),
    .o_count    (w_q_count),
    .o_head_dat (w_head)
  );

  assign IF_VALID       = w_if_valid;
  assign IF_PC          = w_head[2*XLEN-1:XLEN];
  assign IF_INSTRUCTION = w_head[XLEN-1:0];
  assign IF_PC_PLUS4    = IF_PC + XLEN'(4);

  // Full status is implied by the credit; kept only for the overflow assertion.
  logic w_unused;
  assign w_unused = w_q_full;
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized bench for if_prefetch_unit against a stream-level model with an in-order memory.
module tb_if_prefetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REDIRECT_VALID = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        ID_READY = 1'b0;
  logic        IF_VALID;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC_PLUS4;
  logic [31:0] IF_INSTRUCTION;

  if_prefetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .ID_READY(ID_READY), .IF_VALID(IF_VALID), .IF_PC(IF_PC),
    .IF_PC_PLUS4(IF_PC_PLUS4), .IF_INSTRUCTION(IF_INSTRUCTION)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    longint      rdy;
  } mreq_t;

  mreq_t       pending[$];     // requests granted by memory, not yet answered
  logic [63:0] mq[$];          // expected prefetch queue: {pc, instr}
  logic [31:0] m_addr;         // next address the fetch stream should request
  int          epoch;
  bit          boot;
  longint      cyc;
  int          n_checks, n_errors, delivered;

  int gnt_pct, rdy_pct, redir_pct, lat_min, lat_max;
  bit          force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit          rv, exp_req, exp_vld;
    mreq_t       e;
    logic [31:0] tgt;
    @(negedge CLK);
    if (!RST) RST = 1'b1;
    if (force_redir) begin
      REDIRECT_VALID = 1'b1;
      REDIRECT_PC    = force_pc;
      force_redir    = 1'b0;
    end else begin
      REDIRECT_VALID = ($urandom_range(99) < redir_pct);
      REDIRECT_PC    = $urandom;
    end
    IMEM_GNT = ($urandom_range(99) < gnt_pct);
    ID_READY = ($urandom_range(99) < rdy_pct);
    rv = (pending.size() > 0) && (pending[0].rdy <= cyc);
    IMEM_RVALID = rv;
    IMEM_RDATA  = rv ? mem_data(pending[0].addr) : $urandom;
    #1;
    exp_req = !boot && !REDIRECT_VALID && (mq.size() + pending.size() < DEPTH);
    exp_vld = (mq.size() > 0) && !REDIRECT_VALID;
    check_eq("imem_req", 32'(IMEM_REQ), 32'(exp_req));
    if (exp_req) check_eq("imem_addr", IMEM_ADDR, m_addr);
    check_eq("if_valid", 32'(IF_VALID), 32'(exp_vld));
    if (exp_vld) begin
      check_eq("if_pc", IF_PC, mq[0][63:32]);
      check_eq("if_pc_plus4", IF_PC_PLUS4, mq[0][63:32] + 32'd4);
      check_eq("if_instr", IF_INSTRUCTION, mq[0][31:0]);
    end
    if (exp_vld && ID_READY) begin
      void'(mq.pop_front());
      delivered++;
    end
    if (rv) begin
      e = pending.pop_front();
      if (!REDIRECT_VALID && e.epoch == epoch) mq.push_back({e.addr, mem_data(e.addr)});
    end
    if (exp_req && IMEM_GNT) begin
      pending.push_back('{addr: m_addr, epoch: epoch,
                          rdy: cyc + longint'($urandom_range(lat_max, lat_min))});
      m_addr = m_addr + 32'd4;
    end
    if (REDIRECT_VALID) begin
      epoch++;
      mq.delete();
      tgt    = REDIRECT_PC;
      m_addr = {tgt[31:2], 2'b00};
    end
    boot = 1'b0;
    cyc++;
  endtask

  task automatic phase(input int g, input int r, input int rd, input int lmin, input int lmax, input int n);
    gnt_pct = g; rdy_pct = r; redir_pct = rd; lat_min = lmin; lat_max = lmax;
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves RST low; the next step releases it, and that cycle is the boot cycle.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    REDIRECT_VALID = 1'b0; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; ID_READY = 1'b0;
    pending.delete();
    mq.delete();
    m_addr = RESET_PC;
    boot   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("rst_if_valid", 32'(IF_VALID), 32'd0);
      check_eq("rst_imem_req", 32'(IMEM_REQ), 32'd0);
      @(negedge CLK);
    end
    cyc++;
  endtask

  initial begin
    int d0;
    n_checks = 0; n_errors = 0; delivered = 0; cyc = 0; epoch = 0;
    force_redir = 1'b0; force_pc = '0;
    do_reset();

    phase(100, 100, 0, 1, 1, 20);
    d0 = delivered;
    phase(100, 100, 0, 1, 1, 20);
    check_eq("throughput", 32'(delivered - d0), 32'd20);

    phase(100, 0, 0, 1, 1, 12);
    phase(100, 100, 0, 1, 1, 10);

    phase(50, 100, 0, 1, 1, 60);

    phase(100, 100, 0, 3, 3, 10);
    force_redir = 1'b1; force_pc = 32'h0000_0103;
    phase(100, 100, 0, 3, 3, 20);

    force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
    phase(100, 100, 0, 1, 1, 10);

    phase(60, 70, 5, 1, 5, 3000);

    do_reset();
    phase(80, 80, 3, 1, 4, 1500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised successor to the single-cycle fetch stage. It decouples instruction fetch from decode through a request/response instruction-memory interface, so memory may take multiple cycles to return data. A DEPTH-entry prefetch queue holds fetched instructions and their PCs. The unit supports ID-stage backpressure and branch/jump redirects that flush in-flight work. It sits between the PC-select logic and the IF/ID pipeline register.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, prefetch queue entries and max in-flight requests (power of 2, >=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low (0 = reset)
REDIRECT_VALID  in  1  flush and redirect fetch this cycle
REDIRECT_PC  in  XLEN  new fetch address; bits [1:0] ignored
IMEM_REQ  out  1  fetch request valid
IMEM_ADDR  out  XLEN  fetch address, word aligned
IMEM_GNT  in  1  memory accepts request (handshake = REQ & GNT)
IMEM_RVALID  in  1  response valid; responses return in request order
IMEM_RDATA  in  XLEN  instruction word
ID_READY  in  1  decode can accept an instruction
IF_VALID  out  1  head entry valid
IF_PC  out  XLEN  PC of head entry
IF_PC_PLUS4  out  XLEN  IF_PC + 4
IF_INSTRUCTION  out  XLEN  head instruction

Behaviour:
- Reset (RST=0, async):
  - fetch PC = RESET_PC; response PC = RESET_PC.
  - queue empty; outstanding = 0; discard = 0.
  - IF_VALID = 0, IMEM_REQ = 0.
  - Two-state FSM: BOOT → RUN. BOOT lasts exactly one cycle after RST deasserts; IMEM_REQ = 0 in BOOT.
- Issue (RUN):
  - IMEM_REQ = !REDIRECT_VALID && (queue_count + outstanding < DEPTH).
  - IMEM_ADDR = fetch PC.
  - On REQ & GNT: fetch PC += 4 (mod 2^XLEN, 0xFFFFFFFC wraps to 0); outstanding++.
  - REQ may be held without GNT indefinitely; ADDR must stay stable while REQ=1 and GNT=0, unless a redirect occurs.
- Response:
  - On RVALID: outstanding--.
  - If discard > 0 and no redirect this cycle: drop the data; discard--.
  - Otherwise push {response PC, RDATA} into the queue; response PC += 4.
  - The credit rule guarantees no overflow; a push into a full queue is an assertion failure.
- Output:
  - IF_VALID = !empty && !REDIRECT_VALID.
  - IF_PC, IF_PC_PLUS4, IF_INSTRUCTION come from the head entry (registered storage). Values are don't-care when IF_VALID = 0.
  - Pop when IF_VALID & ID_READY.
  - Push and pop in the same cycle are allowed, including when the queue is full. Count is unchanged.
- Latency: a grant in cycle N with RVALID in cycle N+k (k>=1) makes IF_VALID=1 in cycle N+k+1 if the queue was empty. There is no combinational RDATA→IF_INSTRUCTION path.
- Redirect (priority over everything):
  - Queue cleared.
  - fetch PC and response PC = {REDIRECT_PC[XLEN-1:2], 2'b00}.
  - discard = outstanding, after accounting for an RVALID in the same cycle. A response arriving in the redirect cycle belongs to the old stream and is dropped.
  - No request is issued in the redirect cycle.
  - First new-stream request is issued the following cycle.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- Counters: outstanding and discard are clog2(DEPTH+1) bits wide. discard <= outstanding holds always.
- RST asserted mid-operation aborts everything immediately. In-flight memory responses after reset are the memory's responsibility (memory resets on the same RST).

Test Plan:
- Reset release, memory GNT=1 with 1-cycle RVALID, ID_READY=1 → IMEM_ADDR 0x0,0x4,0x8… on consecutive cycles; IF_VALID first high 2 cycles after first grant with IF_PC=0x0, IF_PC_PLUS4=0x4; steady 1 instr/cycle.
- ID_READY=0, DEPTH=4 → exactly 4 grants, then IMEM_REQ=0; queue holds PCs 0x0–0xC. Raising ID_READY drains in order and resumes requests.
- GNT low 3 cycles with REQ high → IMEM_ADDR stable; fetch PC does not advance; no IF_VALID glitch.
- 2 requests outstanding (3-cycle memory latency), REDIRECT_VALID=1, REDIRECT_PC=0x103 → both old responses dropped; next IMEM_ADDR=0x100; first IF_VALID shows IF_PC=0x100, IF_INSTRUCTION=memory[0x100].
- Redirect in the same cycle as RVALID and a valid head pop → IF_VALID=0 that cycle; no pop; old response dropped; discard count correct (no stale instruction ever delivered).
- Redirect to 0xFFFFFFF8 → fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0; IF_PC_PLUS4 of 0xFFFFFFFC = 0x0.
